// File: rtl/dn_pkg.sv
// Shared state encoding and sizing helpers for the Benes network sequencer.
package dn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SET   = 3'd2,
    ST_ROUTE = 3'd3,
    ST_DRAIN = 3'd4
  } dn_state_e;

  function automatic int n_levels(input int n);
    return 2 * $clog2(n) - 1;
  endfunction

  function automatic int cfg_beats(input int route_bits, input int cfg_w);
    return (route_bits + cfg_w - 1) / cfg_w;
  endfunction

endpackage

// File: rtl/dn_valid_pipe.sv
// Tracks in-flight vectors through the network: DEPTH-stage valid shift register
// with synchronous active-low clear and an any-stage-occupied flag.
module dn_valid_pipe #(
  parameter int DEPTH = 9
) (
  input  logic clk,
  input  logic clear_b_i,
  input  logic din_i,
  output logic dout_o,
  output logic any_o
);

  logic [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (!clear_b_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[DEPTH-2:0], din_i};
    end
  end

  assign dout_o = pipe_q[DEPTH-1];
  assign any_o  = |pipe_q;

endmodule

// File: rtl/dn_benes_ctrl.sv
// Sequencer for dn_benes: packs config beats into route signals, pulses set_en,
// streams data vectors with route_en and reports completion once the network drains.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for beat 0 of a configuration
// ST_LOAD  | collecting the remaining config beats
// ST_SET   | net_set_en asserted for this single cycle
// ST_ROUTE | accepting data vectors until the pass count is used up
// ST_DRAIN | waiting for route_en and the latency pipeline to empty
module dn_benes_ctrl
  import dn_pkg::*;
#(
  parameter int N         = 32,
  parameter int DW_DATA   = 32,
  parameter int N_LEVELS  = n_levels(N),
  parameter int CFG_W     = 32,
  parameter int CFG_BEATS = cfg_beats(N_LEVELS * N, CFG_W),
  parameter int NET_LAT   = N_LEVELS,
  parameter int PASS_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CFG_W-1:0]        cfg_data,
  input  logic [PASS_W-1:0]       cfg_passes,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW_DATA*N-1:0]    in_data,
  output logic                    net_set_en,
  output logic                    net_route_en,
  output logic [N_LEVELS*N-1:0]   net_route_signals,
  output logic [DW_DATA*N-1:0]    net_in,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int RS_W   = N_LEVELS * N;
  localparam int PAD_W  = CFG_BEATS * CFG_W;
  localparam int BEAT_W = (CFG_BEATS > 1) ? $clog2(CFG_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CFG_BEATS - 1);

  dn_state_e             state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [PASS_W-1:0]     pass_q, pass_d;
  logic [RS_W-1:0]       shadow_q, shadow_d;
  logic [PAD_W-1:0]      shadow_pad;
  logic [DW_DATA*N-1:0]  net_in_q, net_in_d;
  logic                  set_en_q, set_en_d;
  logic                  route_en_q, route_en_d;
  logic                  done_q, done_d;
  logic                  cfg_fire, in_fire, pipe_any;

  assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign in_ready  = (state_q == ST_ROUTE) && (pass_q != '0);
  assign busy      = (state_q != ST_IDLE);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;

  // Beats land in a padded image so the last beat's surplus bits simply fall off.
  always_comb begin
    shadow_pad = '0;
    shadow_pad[RS_W-1:0] = shadow_q;
    if (cfg_fire) begin
      shadow_pad[int'(beat_q) * CFG_W +: CFG_W] = cfg_data;
    end
    shadow_d = shadow_pad[RS_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    pass_d     = pass_q;
    net_in_d   = net_in_q;
    route_en_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (cfg_fire) begin
          if (beat_q == '0) begin
            pass_d = cfg_passes;
          end
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_SET;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_SET: begin
        state_d = (pass_q != '0) ? ST_ROUTE : ST_DRAIN;
      end
      ST_ROUTE: begin
        if (in_fire) begin
          net_in_d   = in_data;
          route_en_d = 1'b1;
          pass_d     = pass_q - 1'b1;
          if (pass_q == PASS_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!route_en_q && !pipe_any) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign set_en_d = (state_d == ST_SET);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      pass_q     <= '0;
      shadow_q   <= '0;
      net_in_q   <= '0;
      set_en_q   <= 1'b0;
      route_en_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      pass_q     <= pass_d;
      shadow_q   <= shadow_d;
      net_in_q   <= net_in_d;
      set_en_q   <= set_en_d;
      route_en_q <= route_en_d;
      done_q     <= done_d;
    end
  end

  dn_valid_pipe #(
    .DEPTH(NET_LAT)
  ) u_valid_pipe (
    .clk      (clk),
    .clear_b_i(reset),
    .din_i    (route_en_q),
    .dout_o   (out_valid),
    .any_o    (pipe_any)
  );

  assign net_set_en        = set_en_q;
  assign net_route_en      = route_en_q;
  assign net_route_signals = shadow_q;
  assign net_in            = net_in_q;
  assign done              = done_q;

endmodule

// File: tb/tb_dn_benes_ctrl.sv
// Randomized bench for dn_benes_ctrl against a transaction-schedule reference model.
module tb_dn_benes_ctrl;

  localparam int N         = 32;
  localparam int DW_DATA   = 32;
  localparam int N_LEVELS  = 2 * $clog2(N) - 1;
  localparam int CFG_W     = 32;
  localparam int RS_W      = N_LEVELS * N;
  localparam int CFG_BEATS = (RS_W + CFG_W - 1) / CFG_W;
  localparam int NET_LAT   = N_LEVELS;
  localparam int PASS_W    = 16;
  localparam int VW        = DW_DATA * N;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CFG_W-1:0]  cfg_data;
  logic [PASS_W-1:0] cfg_passes;
  logic              in_valid;
  logic              in_ready;
  logic [VW-1:0]     in_data;
  logic              net_set_en;
  logic              net_route_en;
  logic [RS_W-1:0]   net_route_signals;
  logic [VW-1:0]     net_in;
  logic              out_valid;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  dn_benes_ctrl #(
    .N(N), .DW_DATA(DW_DATA), .CFG_W(CFG_W), .PASS_W(PASS_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_passes(cfg_passes),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .net_set_en(net_set_en), .net_route_en(net_route_en),
    .net_route_signals(net_route_signals), .net_in(net_in),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_reset_state();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_route_signals", net_route_signals, '0);
    check_eq("rst_route_en", net_route_en, 1'b0);
    check_eq("rst_set_en", net_set_en, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_net_in", net_in, '0);
    check_eq("rst_cfg_ready", cfg_ready, 1'b1);
    check_eq("rst_in_ready", in_ready, 1'b0);
  endtask

  // cfg_gap < 0 toggles cfg_valid every cycle; abort_after > 0 resets after that many vectors.
  task automatic run_config(input int passes, input int cfg_gap, input int in_gap,
                            input bit seq_beats, input int abort_after);
    logic [CFG_W*CFG_BEATS-1:0] packed_cfg;
    logic [RS_W-1:0]            exp_rs;
    logic [VW-1:0]              last_data;
    bit                         hs_at[int];
    int got, c_last, n_hs, done_cyc, start;
    bit exp_ir, abort_req, aborting, done_now;

    got = 0; packed_cfg = '0; last_data = '0; start = cyc; c_last = cyc;
    while (got < CFG_BEATS) begin
      if (cyc - start > 1000) begin
        check_eq("load_timeout", 1'b1, 1'b0);
        return;
      end
      if (seq_beats)        cfg_valid = 1'b1;
      else if (cfg_gap < 0) cfg_valid = ((cyc - start) % 2 == 0);
      else                  cfg_valid = ($urandom_range(99) >= cfg_gap);
      cfg_data   = seq_beats ? CFG_W'(got + 1) : CFG_W'($urandom);
      cfg_passes = (got == 0) ? PASS_W'(passes) : PASS_W'($urandom);
      in_valid   = 1'($urandom_range(1));
      in_data    = rand_vec();
      @(negedge clk);
      check_eq("cfg_ready_load", cfg_ready, 1'b1);
      check_eq("in_ready_load", in_ready, 1'b0);
      check_eq("busy_load", busy, got > 0);
      check_eq("set_en_load", net_set_en, 1'b0);
      check_eq("out_valid_load", out_valid, 1'b0);
      check_eq("done_load", done, 1'b0);
      if (cfg_valid) begin
        packed_cfg[got*CFG_W +: CFG_W] = cfg_data;
        got++;
      end
      c_last = cyc;
      next_cycle();
    end
    exp_rs = packed_cfg[RS_W-1:0];

    n_hs = 0; abort_req = 0;
    done_cyc = (passes == 0) ? c_last + 3 : -1;
    while (1) begin
      if (cyc - c_last > 2000) begin
        check_eq("drain_timeout", 1'b1, 1'b0);
        break;
      end
      aborting  = abort_req;
      reset     = !aborting;
      cfg_valid = (cyc == done_cyc || aborting) ? 1'b0 : 1'($urandom_range(1));
      cfg_data  = $urandom;
      in_valid  = aborting ? 1'b0 : ($urandom_range(99) >= in_gap);
      in_data   = rand_vec();
      exp_ir    = (cyc >= c_last + 2) && (n_hs < passes);
      @(negedge clk);
      check_eq("set_en", net_set_en, cyc == c_last + 1);
      check_eq("in_ready", in_ready, exp_ir);
      check_eq("cfg_ready_busy", cfg_ready, cyc == done_cyc);
      check_eq("route_signals", net_route_signals, exp_rs);
      check_eq("route_en", net_route_en, hs_at.exists(cyc - 1));
      if (hs_at.exists(cyc - 1)) check_eq("net_in", net_in, last_data);
      check_eq("out_valid", out_valid, hs_at.exists(cyc - NET_LAT - 1));
      check_eq("done", done, cyc == done_cyc);
      check_eq("busy", busy, cyc != done_cyc);
      if (seq_beats && cyc == c_last + 1) begin
        check_eq("rs_first_beat", net_route_signals[CFG_W-1:0], 1);
        check_eq("rs_last_beat", net_route_signals[RS_W-1 -: CFG_W], CFG_BEATS);
      end
      if (in_valid && exp_ir) begin
        hs_at[cyc] = 1'b1;
        last_data  = in_data;
        n_hs++;
        if (n_hs == passes) done_cyc = cyc + NET_LAT + 3;
        if (n_hs == abort_after) abort_req = 1'b1;
      end
      done_now = (cyc == done_cyc);
      next_cycle();
      if (done_now) break;
      if (aborting) begin
        reset = 1'b1; cfg_valid = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_reset_state();
        next_cycle();
        break;
      end
    end
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cfg_valid = 1'b0; cfg_data = '0; cfg_passes = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (3) next_cycle();
    @(negedge clk);
    check_reset_state();
    next_cycle();
    reset = 1'b1;

    run_config(3, 0, 0, 1'b1, 0);
    run_config(0, 20, 0, 1'b0, 0);
    run_config(4, -1, 67, 1'b0, 0);
    run_config(4, 0, 0, 1'b0, 1);
    run_config(2, 0, 0, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      run_config($urandom_range(0, 7), $urandom_range(0, 60), $urandom_range(0, 60), 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
